// File: rtl/wb_memory_interface.sv
// Single-port word RAM behind an Rd/Wr -> Ack/Err handshake with programmable wait states.
// Define MEMIF_ALIGN_CHECK_EN to turn misaligned accesses into Err instead of word accesses.
module wb_memory_interface #(
    parameter int DATAWIDTH_BUS  = 32,
    parameter int MEM_ADDR_WIDTH = 10,
    parameter int WAIT_STATES    = 2
) (
    input  logic                     WB_MemoryInterface_CLOCK_50,
    input  logic                     WB_MemoryInterface_Reset_InHigh,
    input  logic                     WB_MemoryInterface_Rd_In,
    input  logic                     WB_MemoryInterface_Wr_In,
    input  logic [DATAWIDTH_BUS-1:0] WB_MemoryInterface_Addr_In,
    input  logic [DATAWIDTH_BUS-1:0] WB_MemoryInterface_WrData_In,
    output logic [DATAWIDTH_BUS-1:0] WB_MemoryInterface_RdData_Out,
    output logic                     WB_MemoryInterface_Ack_Out,
    output logic                     WB_MemoryInterface_Err_Out,
    output logic                     WB_MemoryInterface_Busy_Out
);
    localparam logic [3:0] WAIT_CNT = 4'(WAIT_STATES);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} stateType;

    logic                      clk;
    logic                      srst;
    stateType                  stateReg;
    logic [3:0]                waitCountReg;
    logic [MEM_ADDR_WIDTH-1:0] idxReg;
    logic [DATAWIDTH_BUS-1:0]  wrDataReg;
    logic                      isWriteReg;
    logic                      errFlagReg;
    logic                      ackReg;
    logic                      errReg;
    logic                      busyReg;
    logic [DATAWIDTH_BUS-1:0]  rdDataReg;

    logic                      reqValid;
    logic                      reqError;
    logic                      misaligned;
    logic                      enterDone;
    logic [MEM_ADDR_WIDTH-1:0] selIdx;
    logic [DATAWIDTH_BUS-1:0]  selData;
    logic                      selWrite;
    logic                      selErr;
    logic                      ramWrite;
    logic                      ramRead;
    logic                      unusedAddrBits;

    logic [DATAWIDTH_BUS-1:0]  memArray [0:(2**MEM_ADDR_WIDTH)-1];

    assign clk  = WB_MemoryInterface_CLOCK_50;
    assign srst = WB_MemoryInterface_Reset_InHigh;

`ifdef MEMIF_ALIGN_CHECK_EN
    assign misaligned = (WB_MemoryInterface_Addr_In[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    // Upper address bits wrap; byte-lane bits only matter when alignment is checked.
    assign unusedAddrBits = ^{WB_MemoryInterface_Addr_In[DATAWIDTH_BUS-1:MEM_ADDR_WIDTH+2],
                              WB_MemoryInterface_Addr_In[1:0]};

    assign reqValid = WB_MemoryInterface_Rd_In | WB_MemoryInterface_Wr_In;
    assign reqError = (WB_MemoryInterface_Rd_In & WB_MemoryInterface_Wr_In) | misaligned;

    // With zero wait states the access commits straight from IDLE, so use the live request.
    always_comb begin
        enterDone = 1'b0;
        selIdx    = idxReg;
        selData   = wrDataReg;
        selWrite  = isWriteReg;
        selErr    = errFlagReg;
        case (stateReg)
            IDLE: begin
                selIdx    = WB_MemoryInterface_Addr_In[MEM_ADDR_WIDTH+1:2];
                selData   = WB_MemoryInterface_WrData_In;
                selWrite  = WB_MemoryInterface_Wr_In;
                selErr    = reqError;
                enterDone = reqValid && (WAIT_CNT == 4'd0);
            end
            WAIT:    enterDone = (waitCountReg <= 4'd1);
            default: enterDone = 1'b0;
        endcase
    end

    assign ramWrite = enterDone & ~srst & ~selErr &  selWrite;
    assign ramRead  = enterDone & ~srst & ~selErr & ~selWrite;

    always_ff @(posedge clk) begin
        if (srst) begin
            stateReg     <= IDLE;
            waitCountReg <= 4'd0;
            idxReg       <= '0;
            wrDataReg    <= '0;
            isWriteReg   <= 1'b0;
            errFlagReg   <= 1'b0;
            ackReg       <= 1'b0;
            errReg       <= 1'b0;
            busyReg      <= 1'b0;
        end else begin
            ackReg <= 1'b0;
            errReg <= 1'b0;
            if (enterDone) begin
                ackReg <= ~selErr;
                errReg <= selErr;
            end
            case (stateReg)
                IDLE: begin
                    if (reqValid) begin
                        idxReg       <= selIdx;
                        wrDataReg    <= selData;
                        isWriteReg   <= selWrite;
                        errFlagReg   <= selErr;
                        waitCountReg <= WAIT_CNT;
                        busyReg      <= 1'b1;
                        stateReg     <= enterDone ? DONE : WAIT;
                    end
                end
                WAIT: begin
                    waitCountReg <= waitCountReg - 4'd1;
                    if (enterDone) begin
                        stateReg <= DONE;
                    end
                end
                default: begin
                    stateReg <= IDLE;
                    busyReg  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (ramWrite) begin
            memArray[selIdx] <= selData;
        end
    end

    // Read data is only refreshed by a successful read and held otherwise.
    always_ff @(posedge clk) begin
        if (srst) begin
            rdDataReg <= '0;
        end else if (ramRead) begin
            rdDataReg <= memArray[selIdx];
        end
    end

    assign WB_MemoryInterface_RdData_Out = rdDataReg;
    assign WB_MemoryInterface_Ack_Out    = ackReg;
    assign WB_MemoryInterface_Err_Out    = errReg;
    assign WB_MemoryInterface_Busy_Out   = busyReg;

endmodule
